exec_arith_unit: RTL and testbench

//   Execute-stage arithmetic core of the 5-stage MIPS pipeline.
//   - Decodes ALUop + funct into a 3-bit ALU operation.
//   - Runs the 32-bit ALU with zero detect.
//   - Computes the branch target pc_inc + (offset << 2) with a 32-bit adder.
//   - Results are registered and feed the EX/MEM pipeline fields.

---
 rtl/exec_pkg.sv | 31 +++
 rtl/exec_arith_unit_if.sv | 28 ++
 rtl/alu_ctrl_dec.sv | 34 +++
 rtl/exec_arith_unit.sv | 61 ++++++
 tb/tb_exec_arith_unit.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/exec_pkg.sv
// Shared encodings for the execute-stage arithmetic core: ALUop, funct and
// the internal ALU operation codes.
package exec_pkg;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_RTYPE = 3'b010;
    localparam logic [2:0] ALUOP_AND   = 3'b011;
    localparam logic [2:0] ALUOP_OR    = 3'b100;
    localparam logic [2:0] ALUOP_SLT   = 3'b101;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    localparam logic [2:0] CTRL_AND    = 3'b000;
    localparam logic [2:0] CTRL_OR     = 3'b001;
    localparam logic [2:0] CTRL_ADD    = 3'b010;
    localparam logic [2:0] CTRL_NOR    = 3'b011;
    localparam logic [2:0] CTRL_XOR    = 3'b100;
    localparam logic [2:0] CTRL_UNUSED = 3'b101;
    localparam logic [2:0] CTRL_SUB    = 3'b110;
    localparam logic [2:0] CTRL_SLT    = 3'b111;

endpackage

// File: rtl/exec_arith_unit_if.sv
// Operand/control inputs and registered EX/MEM results of the arithmetic core.
// master drives operands (decode stage side); slave is the arithmetic unit.
interface exec_arith_unit_if #(
    parameter int WIDTH = 32
);
    logic             en;
    logic [2:0]       alu_op;
    logic             alu_src;
    logic [5:0]       funct;
    logic [WIDTH-1:0] reg_data1;
    logic [WIDTH-1:0] reg_data2;
    logic [WIDTH-1:0] sext_imm;
    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] alu_result;
    logic             zero;
    logic [WIDTH-1:0] branch_addr;
    logic [2:0]       alu_ctrl;

    modport master (
        output en, alu_op, alu_src, funct, reg_data1, reg_data2, sext_imm, pc_inc,
        input  alu_result, zero, branch_addr, alu_ctrl
    );

    modport slave (
        input  en, alu_op, alu_src, funct, reg_data1, reg_data2, sext_imm, pc_inc,
        output alu_result, zero, branch_addr, alu_ctrl
    );
endinterface

// File: rtl/alu_ctrl_dec.sv
// Combinational ALUop/funct decode into the 3-bit ALU operation code.
module alu_ctrl_dec
    import exec_pkg::*;
(
    input  logic [2:0] alu_op,
    input  logic [5:0] funct,
    output logic [2:0] ctrl
);

    always_comb begin
        ctrl = CTRL_ADD;
        case (alu_op)
            ALUOP_ADD: ctrl = CTRL_ADD;
            ALUOP_SUB: ctrl = CTRL_SUB;
            ALUOP_AND: ctrl = CTRL_AND;
            ALUOP_OR:  ctrl = CTRL_OR;
            ALUOP_SLT: ctrl = CTRL_SLT;
            ALUOP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_ADDU: ctrl = CTRL_ADD;
                    FN_SUB, FN_SUBU: ctrl = CTRL_SUB;
                    FN_AND:          ctrl = CTRL_AND;
                    FN_OR:           ctrl = CTRL_OR;
                    FN_XOR:          ctrl = CTRL_XOR;
                    FN_NOR:          ctrl = CTRL_NOR;
                    FN_SLT:          ctrl = CTRL_SLT;
                    default:         ctrl = CTRL_ADD;
                endcase
            end
            default: ctrl = CTRL_ADD;
        endcase
    end

endmodule

// File: rtl/exec_arith_unit.sv
// Execute-stage arithmetic core: operand select, ALU with zero detect and
// branch-target adder, all registered into the EX/MEM fields.
module exec_arith_unit
    import exec_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    exec_arith_unit_if.slave   bus
);

    logic [2:0]       ctrl;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] branch_sum;
    logic             less;

    alu_ctrl_dec u_dec (
        .alu_op (bus.alu_op),
        .funct  (bus.funct),
        .ctrl   (ctrl)
    );

    assign op_a = bus.reg_data1;
    assign op_b = bus.alu_src ? bus.sext_imm : bus.reg_data2;
    assign less = $signed(op_a) < $signed(op_b);

    always_comb begin
        alu_res = '0;
        case (ctrl)
            CTRL_AND: alu_res = op_a & op_b;
            CTRL_OR:  alu_res = op_a | op_b;
            CTRL_ADD: alu_res = op_a + op_b;
            CTRL_NOR: alu_res = ~(op_a | op_b);
            CTRL_XOR: alu_res = op_a ^ op_b;
            CTRL_SUB: alu_res = op_a - op_b;
            CTRL_SLT: alu_res = {{(WIDTH-1){1'b0}}, less};
            default:  alu_res = '0;
        endcase
    end

    // Word offset: the top two offset bits fall off the shift, sum wraps.
    assign branch_sum = bus.pc_inc + {bus.sext_imm[WIDTH-3:0], 2'b00};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.alu_result  <= '0;
            bus.zero        <= 1'b0;
            bus.branch_addr <= '0;
            bus.alu_ctrl    <= '0;
        end else if (bus.en) begin
            bus.alu_result  <= alu_res;
            bus.zero        <= (alu_res == '0);
            bus.branch_addr <= branch_sum;
            bus.alu_ctrl    <= ctrl;
        end
    end

endmodule

// File: tb/tb_exec_arith_unit.sv
// Directed-vector bench for exec_arith_unit with hand-computed expectations.
module tb_exec_arith_unit;

    typedef struct packed {
        logic [2:0]  op;
        logic        src;
        logic [5:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] res;
        logic        z;
        logic [31:0] br;
        logic [2:0]  ctrl;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad = 0;

    exec_arith_unit_if #(.WIDTH(32)) bus ();

    exec_arith_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v);
        bus.alu_op    = v.op;
        bus.alu_src   = v.src;
        bus.funct     = v.f;
        bus.reg_data1 = v.a;
        bus.reg_data2 = v.b;
        bus.sext_imm  = v.imm;
        bus.pc_inc    = v.pc;
    endtask

    task automatic test_reset();
        vec_t v;
        rst_n  = 1'b0;
        bus.en = 1'b1;
        apply('{3'b010, 1'b0, 6'h20, 32'hDEAD0001, 32'h0000BEEF, 32'h00000123, 32'h00400000,
                32'h0, 1'b0, 32'h0, 3'b0});
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if ({bus.alu_result, bus.zero, bus.branch_addr, bus.alu_ctrl} !== 68'h0) begin
                $display("FAIL reset[%0d]: got res=%h z=%b br=%h ctrl=%b want all zero",
                         i, bus.alu_result, bus.zero, bus.branch_addr, bus.alu_ctrl);
                bad++;
            end
        end
        v = '{3'b010, 1'b0, 6'h20, 32'd5, 32'd7, 32'h10, 32'h100, 32'd12, 1'b0, 32'h140, 3'b010};
        apply(v);
        rst_n = 1'b1;
        tick();
        total++;
        if ({bus.alu_result, bus.zero, bus.branch_addr, bus.alu_ctrl} !== {v.res, v.z, v.br, v.ctrl}) begin
            $display("FAIL reset_release: got res=%h z=%b br=%h ctrl=%b want res=%h z=%b br=%h ctrl=%b",
                     bus.alu_result, bus.zero, bus.branch_addr, bus.alu_ctrl, v.res, v.z, v.br, v.ctrl);
            bad++;
        end
    endtask

    task automatic test_ops();
        vec_t v[16];
        v[0]  = '{3'b010, 1'b0, 6'h20, 32'd5,        32'd7,        32'h10,       32'h100,  32'd12,       1'b0, 32'h140,      3'b010};
        v[1]  = '{3'b001, 1'b0, 6'h00, 32'h1234,     32'h1234,     32'hFFFFFFFF, 32'd8,    32'h0,        1'b1, 32'h4,        3'b110};
        v[2]  = '{3'b010, 1'b0, 6'h2A, 32'hFFFFFFFF, 32'd1,        32'h0,        32'h20,   32'd1,        1'b0, 32'h20,       3'b111};
        v[3]  = '{3'b010, 1'b0, 6'h2A, 32'd1,        32'hFFFFFFFF, 32'h0,        32'h20,   32'd0,        1'b1, 32'h20,       3'b111};
        v[4]  = '{3'b000, 1'b1, 6'h00, 32'hFFFFFFFF, 32'h55,       32'd1,        32'h0,    32'h0,        1'b1, 32'h4,        3'b010};
        v[5]  = '{3'b011, 1'b1, 6'h00, 32'hF0F01234, 32'hFFFFFFFF, 32'h0000FF00, 32'h1000, 32'h00001200, 1'b0, 32'h00040C00, 3'b000};
        v[6]  = '{3'b100, 1'b1, 6'h00, 32'hF0000000, 32'h0,        32'h000000FF, 32'h0,    32'hF00000FF, 1'b0, 32'h3FC,      3'b001};
        v[7]  = '{3'b010, 1'b0, 6'h26, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0,        32'h4,    32'hF00FF00F, 1'b0, 32'h4,        3'b100};
        v[8]  = '{3'b010, 1'b0, 6'h27, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0,        32'h4,    32'h00F000F0, 1'b0, 32'h4,        3'b011};
        v[9]  = '{3'b010, 1'b0, 6'h22, 32'd3,        32'd5,        32'h0,        32'h0,    32'hFFFFFFFE, 1'b0, 32'h0,        3'b110};
        v[10] = '{3'b010, 1'b0, 6'h23, 32'd7,        32'd7,        32'h0,        32'h0,    32'h0,        1'b1, 32'h0,        3'b110};
        v[11] = '{3'b101, 1'b1, 6'h00, 32'd5,        32'd9,        32'hFFFFFFFF, 32'h0,    32'h0,        1'b1, 32'hFFFFFFFC, 3'b111};
        v[12] = '{3'b110, 1'b0, 6'h24, 32'd2,        32'd3,        32'h0,        32'h0,    32'd5,        1'b0, 32'h0,        3'b010};
        v[13] = '{3'b111, 1'b0, 6'h25, 32'd2,        32'd3,        32'h0,        32'h0,    32'd5,        1'b0, 32'h0,        3'b010};
        v[14] = '{3'b010, 1'b0, 6'h21, 32'h7FFFFFFF, 32'd1,        32'h0,        32'h0,    32'h80000000, 1'b0, 32'h0,        3'b010};
        v[15] = '{3'b000, 1'b0, 6'h00, 32'h0,        32'h0,        32'hC0000001, 32'h10,   32'h0,        1'b1, 32'h14,       3'b010};
        bus.en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            apply(v[i]);
            tick();
            total++;
            if ({bus.alu_result, bus.zero, bus.branch_addr, bus.alu_ctrl} !== {v[i].res, v[i].z, v[i].br, v[i].ctrl}) begin
                $display("FAIL ops[%0d]: got res=%h z=%b br=%h ctrl=%b want res=%h z=%b br=%h ctrl=%b",
                         i, bus.alu_result, bus.zero, bus.branch_addr, bus.alu_ctrl,
                         v[i].res, v[i].z, v[i].br, v[i].ctrl);
                bad++;
            end
        end
    endtask

    task automatic test_hold();
        vec_t v;
        v = '{3'b010, 1'b0, 6'h22, 32'd3, 32'd5, 32'h1, 32'h40, 32'hFFFFFFFE, 1'b0, 32'h44, 3'b110};
        bus.en = 1'b1;
        apply(v);
        tick();
        bus.en = 1'b0;
        apply('{3'b001, 1'b1, 6'h00, 32'h9, 32'h9, 32'h9, 32'h1000, 32'h0, 1'b0, 32'h0, 3'b0});
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if ({bus.alu_result, bus.zero, bus.branch_addr, bus.alu_ctrl} !== {v.res, v.z, v.br, v.ctrl}) begin
                $display("FAIL hold[%0d]: got res=%h z=%b br=%h ctrl=%b want res=%h z=%b br=%h ctrl=%b",
                         i, bus.alu_result, bus.zero, bus.branch_addr, bus.alu_ctrl, v.res, v.z, v.br, v.ctrl);
                bad++;
            end
        end
        v = '{3'b010, 1'b0, 6'h3F, 32'd10, 32'd20, 32'h2, 32'h0, 32'd30, 1'b0, 32'h8, 3'b010};
        apply(v);
        bus.en = 1'b1;
        tick();
        total++;
        if ({bus.alu_result, bus.zero, bus.branch_addr, bus.alu_ctrl} !== {v.res, v.z, v.br, v.ctrl}) begin
            $display("FAIL unknown_funct: got res=%h z=%b br=%h ctrl=%b want res=%h z=%b br=%h ctrl=%b",
                     bus.alu_result, bus.zero, bus.branch_addr, bus.alu_ctrl, v.res, v.z, v.br, v.ctrl);
            bad++;
        end
    endtask

    task automatic test_reset_ignores_en();
        bus.en = 1'b0;
        rst_n  = 1'b0;
        tick();
        total++;
        if ({bus.alu_result, bus.zero, bus.branch_addr, bus.alu_ctrl} !== 68'h0) begin
            $display("FAIL reset_en0: got res=%h z=%b br=%h ctrl=%b want all zero",
                     bus.alu_result, bus.zero, bus.branch_addr, bus.alu_ctrl);
            bad++;
        end
        rst_n = 1'b1;
        apply('{3'b010, 1'b0, 6'h20, 32'd1, 32'd1, 32'h1, 32'h1, 32'h0, 1'b0, 32'h0, 3'b0});
        tick();
        total++;
        if ({bus.alu_result, bus.zero, bus.branch_addr, bus.alu_ctrl} !== 68'h0) begin
            $display("FAIL hold_after_reset: got res=%h z=%b br=%h ctrl=%b want all zero",
                     bus.alu_result, bus.zero, bus.branch_addr, bus.alu_ctrl);
            bad++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.en = 1'b0;
        test_reset();
        test_ops();
        test_hold();
        test_reset_ignores_en();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
